multicycle_cpu_core: RTL
========================

// Module: multicycle_cpu_core
// PURPOSE
//  Parametrised multicycle processor core: fetch/decode/execute FSM, 16-entry register file, ALU.
//  Fixed 16-bit instructions (op[15:12]) over a 9-op ISA: NOOP..HALT plus LDI, JMP and JZ.
//  Instruction and data memories are external, each behind a req/ack handshake, so wait states are tolerated.
//  Sits between the program ROM and the data RAM; replaces the fixed-width, fixed-latency core.
// PARAMETERS
//  DATA_W    16  register/ALU/data-memory word width (>=8)
//  PC_W       8  program counter width; instruction address space 2^PC_W
//  RESET_PC   0  PC value loaded on reset
// PORTS
//  clock        in   1        rising-edge clock
//  reset        in   1        asynchronous, active-low reset
//  imem_req     out  1        instruction fetch request
//  imem_addr    out  PC_W     fetch address (= PC)
//  imem_ack     in   1        fetch complete; imem_rdata valid this cycle
//  imem_rdata   in   16       instruction word
//  dmem_req     out  1        data access request
//  dmem_we      out  1        1=write (STORE), 0=read (LOAD); valid while dmem_req=1
//  dmem_addr    out  8        data address
//  dmem_wdata   out  DATA_W   store data
//  dmem_ack     in   1        access complete; dmem_rdata valid this cycle for reads
//  dmem_rdata   in   DATA_W   load data
//  dbg_sel      in   4        register-file debug read select
//  dbg_data     out  DATA_W   R[dbg_sel], combinational
//  pc_out       out  PC_W     current PC
//  ir_out       out  16       instruction register
//  state_out    out  3        FSM state encoding
//  halted       out  1        1 while in HALT
//  illegal_op   out  1        one-cycle pulse in DECODE for opcodes 9..F
// BEHAVIOUR
//  Reset (async, reset=0): state=FETCH, PC=RESET_PC, IR=0, R0..R15=0, all req/we outputs 0, halted=0, illegal_op=0.
//  States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
//  FETCH: imem_req=1, imem_addr=PC. On the edge with imem_ack=1: IR<=imem_rdata, PC<=PC+1 (wraps mod 2^PC_W), ->DECODE.
//  DECODE: read operands. LOAD/STORE ->MEM; HALT ->HALT; everything else ->EXEC.
//  EXEC: on the clock edge:
//   ADD 3 Ra[11:8] Rb[7:4] Rd[3:0]: Rd<=Ra+Rb. SUB 4 (same fields): Rd<=Ra-Rb. Both mod 2^DATA_W; no flags.
//   LDI 6 imm[11:4] Rd[3:0]: Rd<=sign-extend(imm8) to DATA_W.
//   JMP 7: PC<=IR[7:0], zero-extended or truncated to PC_W.
//   JZ 8 Ra[11:8] tgt[7:0]: if R[Ra]==0, PC<=tgt (same width rule); otherwise PC unchanged.
//   NOOP 0 and illegal 9..F: no architectural effect.
//   Then ->FETCH.
//  MEM: dmem_req=1.
//   STORE 1 Ra[11:8] addr[7:0]: dmem_we=1, dmem_wdata=R[Ra]. On ack ->FETCH.
//   LOAD 2 addr[11:4] Rd[3:0]: dmem_we=0. On ack, capture dmem_rdata ->WB.
//  WB: Rd<=captured data ->FETCH.
//  Handshake: req goes high on state entry. Addr/we/wdata are held stable until ack is sampled high.
//   ack may arrive in the same cycle req first rises (zero-wait). req is 0 in the cycle after ack.
//   ack while req=0 is ignored. Each request completes exactly once.
//  Latency with zero-wait memories: ALU/LDI/JMP/JZ/NOOP 3 cycles, STORE 3, LOAD 4. Each memory wait cycle adds 1.
//  HALT 5: halted=1, no requests; stays in HALT until reset.
//  Register writes occur only in EXEC (ADD/SUB/LDI) or WB. A read of Rd in the next instruction sees the new value.
//  Reset mid-transaction: req drops immediately (asynchronously); the core restarts at RESET_PC.
//   Any ack arriving later is ignored. The memory must tolerate abandoned requests.
// TESTING
//  1 Hold reset=0 for 3 cycles, release -> imem_req=1, imem_addr=0, every dbg_data=0, halted=0.
//  2 DATA_W=16 program: LDI R1,5; LDI R2,-3; ADD R3,R1,R2; SUB R4,R2,R1; STORE R3,0x10; HALT.
//    -> one dmem write, addr 0x10, data 0x0002; R4=0xFFF8; halted=1 at cycle 18; no requests afterwards.
//  3 imem_ack delayed 3 cycles on one fetch -> imem_addr and imem_req stable throughout; PC increments exactly once.
//  4 LOAD 0x22->R5 with dmem_ack delayed 2 cycles, rdata=0xBEEF -> dmem_we=0, addr 0x22; R5=0xBEEF after WB.
//  5 JZ R0,0x40 with R0=0 -> PC=0x40. JZ with R1=1 -> PC=next. PC_W=4: fetch at PC 15 wraps to 0; JMP 0xFF -> PC=0xF.
//  6 Assert reset during MEM with dmem_req=1 -> req=0 immediately; late ack ignored; first fetch after release at RESET_PC.

Source files
------------

// File: rtl/multicycle_cpu_core_if.sv
// Memory-side bus of the multicycle core: one instruction port and one data port.
//
// Handshake (both ports): the core raises req on entering the access state and
// holds addr/we/wdata stable until it samples ack=1 on a rising clock edge.
// ack may be high in the same cycle req first rises (zero wait). req is 0 in the
// cycle after the accepted ack. An ack seen while req=0 is ignored. Every request
// completes exactly once, unless reset abandons it.
//
// Signals:
//   imem_req/imem_addr (core->mem), imem_ack/imem_rdata (mem->core)
//   dmem_req/dmem_we/dmem_addr/dmem_wdata (core->mem), dmem_ack/dmem_rdata (mem->core)
interface multicycle_cpu_core_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8
);
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [15:0]       imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic [7:0]        dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, input imem_ack, imem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_ack, dmem_rdata
  );

  modport slave (
    input imem_req, imem_addr, output imem_ack, imem_rdata,
    input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/multicycle_cpu_core.sv
// Multicycle processor core: FETCH/DECODE/EXEC/MEM/WB/HALT FSM, 16-entry
// register file and ALU, 16-bit instructions with the opcode in [15:12].
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-low reset
//   mem        memory bus (master side): instruction and data req/ack ports
//   dbg_sel    register-file debug read select
//   dbg_data   R[dbg_sel], combinational
//   pc_out     current PC
//   ir_out     instruction register
//   state_out  FSM state (FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5)
//   halted     1 while in HALT
//   illegal_op one-cycle pulse in DECODE for opcodes 9..F
module multicycle_cpu_core #(
  parameter int DATA_W   = 16,
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  multicycle_cpu_core_if.master mem,
  input  logic [3:0]           dbg_sel,
  output logic [DATA_W-1:0]    dbg_data,
  output logic [PC_W-1:0]      pc_out,
  output logic [15:0]          ir_out,
  output logic [2:0]           state_out,
  output logic                 halted,
  output logic                 illegal_op
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h5;
  localparam logic [3:0] OP_LDI   = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] ld_q, ld_d;
  logic [DATA_W-1:0] rf_q [16];
  logic [DATA_W-1:0] rf_d [16];

  logic [3:0]        op, ra, rb, rd;
  logic [PC_W-1:0]   jmp_tgt;
  logic [DATA_W-1:0] ldi_val;

  assign op = ir_q[15:12];
  assign ra = ir_q[11:8];
  assign rb = ir_q[7:4];
  assign rd = ir_q[3:0];

  // Sign-extend the 8-bit LDI immediate to the datapath width.
  assign ldi_val = DATA_W'($signed(ir_q[11:4]));

  // Jump target is IR[7:0], zero-extended or truncated to the PC width.
  if (PC_W >= 8) begin : g_tgt_ext
    assign jmp_tgt = PC_W'(ir_q[7:0]);
  end else begin : g_tgt_trunc
    assign jmp_tgt = ir_q[PC_W-1:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      pc_q    <= PC_W'(RESET_PC);
      ir_q    <= '0;
      ld_q    <= '0;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ld_q    <= ld_d;
      for (int i = 0; i < 16; i++) rf_q[i] <= rf_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ld_d    = ld_q;
    rf_d    = rf_q;
    case (state_q)
      ST_FETCH: begin
        if (mem.imem_ack) begin
          ir_d    = mem.imem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (op)
          OP_STORE, OP_LOAD: state_d = ST_MEM;
          OP_HALT:           state_d = ST_HALT;
          default:           state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (op)
          OP_ADD: rf_d[rd] = rf_q[ra] + rf_q[rb];
          OP_SUB: rf_d[rd] = rf_q[ra] - rf_q[rb];
          OP_LDI: rf_d[rd] = ldi_val;
          OP_JMP: pc_d = jmp_tgt;
          OP_JZ:  if (rf_q[ra] == '0) pc_d = jmp_tgt;
          default: ;
        endcase
        state_d = ST_FETCH;
      end
      ST_MEM: begin
        if (mem.dmem_ack) begin
          if (op == OP_LOAD) begin
            ld_d    = mem.dmem_rdata;
            state_d = ST_WB;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        rf_d[rd] = ld_q;
        state_d  = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // Requests are gated by reset so they drop the instant reset is asserted,
  // not at the next clock edge.
  assign mem.imem_req   = reset && (state_q == ST_FETCH);
  assign mem.imem_addr  = pc_q;
  assign mem.dmem_req   = reset && (state_q == ST_MEM);
  assign mem.dmem_we    = mem.dmem_req && (op == OP_STORE);
  assign mem.dmem_addr  = (op == OP_STORE) ? ir_q[7:0] : ir_q[11:4];
  assign mem.dmem_wdata = rf_q[ra];

  assign dbg_data   = rf_q[dbg_sel];
  assign pc_out     = pc_q;
  assign ir_out     = ir_q;
  assign state_out  = state_q;
  assign halted     = (state_q == ST_HALT);
  assign illegal_op = (state_q == ST_DECODE) && (op > OP_JZ);

endmodule
